// File: rtl/stone_pkg.sv
// Shared definitions for the stone RAM access path: record layout,
// requester ownership tags and arbiter states.
package stone_pkg;

  localparam int STONE_ADDR_W = 4;
  localparam int STONE_DATA_W = 32;

  // Stone record field positions
  localparam int STONE_X_MSB       = 31;
  localparam int STONE_X_LSB       = 23;
  localparam int STONE_Y_MSB       = 18;
  localparam int STONE_Y_LSB       = 11;
  localparam int STONE_TYPE_MSB    = 3;
  localparam int STONE_TYPE_LSB    = 2;
  localparam int STONE_VISIBLE_BIT = 1;
  localparam int STONE_MOVING_BIT  = 0;

  // Which requester owns the read return of a grant
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DRAW,
    OWN_ROPE
  } owner_e;

  // Arbiter states
  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/stone_rd_return.sv
// Read return path: remembers who was granted a read and from which bank,
// then steers the bank output to that requester one cycle later.
module stone_rd_return
  import stone_pkg::*;
#(
  parameter int DATA_W = STONE_DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  owner_e            gnt_owner,
  input  logic              bank_sel,
  input  logic [DATA_W-1:0] ram_q0,
  input  logic [DATA_W-1:0] ram_q1,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  output logic              rope_rvalid,
  output logic [DATA_W-1:0] rope_rdata
);

  owner_e            owner_reg;
  logic              bank_reg;
  logic [DATA_W-1:0] q_sel;
  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_arr [2];

  // One-cycle pipeline of read owner and bank, matching the RAM latency
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner_reg <= OWN_NONE;
      bank_reg  <= 1'b0;
    end else begin
      owner_reg <= gnt_owner;
      bank_reg  <= bank_sel;
    end
  end

  // The bank chosen at grant time supplies the data, not the current one
  assign q_sel = bank_reg ? ram_q1 : ram_q0;

  // Index 0 is the drawer, index 1 is the rope
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    localparam owner_e REQ_OWNER = owner_e'((gi == 0) ? OWN_DRAW : OWN_ROPE);
    logic [DATA_W-1:0] hold_reg;

    assign rvalid_vec[gi] = (owner_reg == REQ_OWNER);

    // Capture the returned word so rdata stays stable until the next valid
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        hold_reg <= '0;
      end else if (rvalid_vec[gi]) begin
        hold_reg <= q_sel;
      end
    end

    // Present the live RAM word in the valid cycle, the held word otherwise
    assign rdata_arr[gi] = rvalid_vec[gi] ? q_sel : hold_reg;
  end

  assign draw_rvalid = rvalid_vec[0];
  assign draw_rdata  = rdata_arr[0];
  assign rope_rvalid = rvalid_vec[1];
  assign rope_rdata  = rdata_arr[1];

endmodule

// File: rtl/stone_ram_arbiter.sv
// Single access point to the two per-level stone RAM banks. The drawer
// normally wins; a starvation counter lets the rope through, and the rope
// can lock the arbiter for an atomic read-modify-write.
module stone_ram_arbiter
  import stone_pkg::*;
#(
  parameter int ADDR_W       = STONE_ADDR_W,
  parameter int DATA_W       = STONE_DATA_W,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [2:0]        level,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  input  logic              rope_req,
  input  logic              rope_we,
  input  logic              rope_lock,
  input  logic [ADDR_W-1:0] rope_addr,
  input  logic [DATA_W-1:0] rope_wdata,
  output logic              rope_gnt,
  output logic              rope_rvalid,
  output logic [DATA_W-1:0] rope_rdata,
  output logic              lock_active,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren0,
  output logic              ram_wren1,
  input  logic [DATA_W-1:0] ram_q0,
  input  logic [DATA_W-1:0] ram_q1
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int LOCK_W   = $clog2(LOCK_MAX);

  arb_state_e          state_reg;
  logic                bank_sel_reg;
  logic [STARVE_W-1:0] starve_cnt_reg;
  logic [LOCK_W-1:0]   lock_cnt_reg;
  logic                starved;
  owner_e              gnt_owner;

  assign starved = (starve_cnt_reg >= STARVE_W'(STARVE_LIMIT));

  // Grant decision: rope only while locked, otherwise drawer unless the rope is starved
  always_comb begin
    draw_gnt = 1'b0;
    rope_gnt = 1'b0;
    if (resetn) begin
      if (state_reg == ARB_LOCKED) begin
        rope_gnt = rope_req;
      end else if (draw_req && !(starved && rope_req)) begin
        draw_gnt = 1'b1;
      end else begin
        rope_gnt = rope_req;
      end
    end
  end

  // Granted requester drives the shared RAM address/data in the same cycle
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    gnt_owner = OWN_NONE;
    if (draw_gnt) begin
      ram_addr  = draw_addr;
      gnt_owner = OWN_DRAW;
    end else if (rope_gnt) begin
      ram_addr  = rope_addr;
      ram_wdata = rope_wdata;
      gnt_owner = rope_we ? OWN_NONE : OWN_ROPE;
    end
  end

  assign ram_wren0   = rope_gnt & rope_we & ~bank_sel_reg;
  assign ram_wren1   = rope_gnt & rope_we &  bank_sel_reg;
  assign lock_active = (state_reg == ARB_LOCKED);

  // Lock FSM: enter on a locking rope grant, leave on unlock or timeout
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ARB_IDLE;
      lock_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (rope_gnt && rope_lock) begin
            state_reg    <= ARB_LOCKED;
            lock_cnt_reg <= '0;
          end
        end
        ARB_LOCKED: begin
          if (lock_cnt_reg == LOCK_W'(LOCK_MAX - 1)) begin
            state_reg <= ARB_IDLE;
          end else if (!rope_lock && (rope_gnt || !rope_req)) begin
            state_reg <= ARB_IDLE;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  // Count consecutive cycles the rope waits, saturating at the limit
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_reg <= '0;
    end else if (!rope_req || rope_gnt) begin
      starve_cnt_reg <= '0;
    end else if (!starved) begin
      starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
    end
  end

  // Follow the level only on quiet idle cycles so no access straddles banks
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bank_sel_reg <= 1'b0;
    end else if (state_reg == ARB_IDLE && !draw_gnt && !rope_gnt) begin
      bank_sel_reg <= (level != 3'd0);
    end
  end

  stone_rd_return #(
    .DATA_W (DATA_W)
  ) u_rd_return (
    .clock       (clock),
    .resetn      (resetn),
    .gnt_owner   (gnt_owner),
    .bank_sel    (bank_sel_reg),
    .ram_q0      (ram_q0),
    .ram_q1      (ram_q1),
    .draw_rvalid (draw_rvalid),
    .draw_rdata  (draw_rdata),
    .rope_rvalid (rope_rvalid),
    .rope_rdata  (rope_rdata)
  );

endmodule

// File: tb/tb_stone_ram_arbiter.sv
// Directed bench for stone_ram_arbiter with a two-bank new-data RAM model.
module tb_stone_ram_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [2:0]  level;
  logic        draw_req;
  logic [3:0]  draw_addr;
  logic        draw_gnt;
  logic        draw_rvalid;
  logic [31:0] draw_rdata;
  logic        rope_req;
  logic        rope_we;
  logic        rope_lock;
  logic [3:0]  rope_addr;
  logic [31:0] rope_wdata;
  logic        rope_gnt;
  logic        rope_rvalid;
  logic [31:0] rope_rdata;
  logic        lock_active;
  logic [3:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren0;
  logic        ram_wren1;
  logic [31:0] ram_q0;
  logic [31:0] ram_q1;

  int checks = 0;
  int errors = 0;
  int k;
  int n;
  logic saw;

  always #5 clock = ~clock;

  stone_ram_arbiter dut (
    .clock       (clock),
    .resetn      (resetn),
    .level       (level),
    .draw_req    (draw_req),
    .draw_addr   (draw_addr),
    .draw_gnt    (draw_gnt),
    .draw_rvalid (draw_rvalid),
    .draw_rdata  (draw_rdata),
    .rope_req    (rope_req),
    .rope_we     (rope_we),
    .rope_lock   (rope_lock),
    .rope_addr   (rope_addr),
    .rope_wdata  (rope_wdata),
    .rope_gnt    (rope_gnt),
    .rope_rvalid (rope_rvalid),
    .rope_rdata  (rope_rdata),
    .lock_active (lock_active),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wren0   (ram_wren0),
    .ram_wren1   (ram_wren1),
    .ram_q0      (ram_q0),
    .ram_q1      (ram_q1)
  );

  // Two RAM banks, one-cycle read latency, new-data on write
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic        init_done = 1'b0;

  function automatic logic [31:0] init_val(input logic bank, input int idx);
    logic [3:0] a;
    a = idx[3:0];
    if (!bank && idx == 3) return 32'h1234_5678;
    return {(bank ? 16'hB1B1 : 16'hA0A0), 12'h000, a};
  endfunction

  always @(posedge clock) begin
    if (!init_done) begin
      init_done <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= init_val(1'b0, i);
        mem1[i] <= init_val(1'b1, i);
      end
      ram_q0 <= '0;
      ram_q1 <= '0;
    end else begin
      if (ram_wren0) mem0[ram_addr] <= ram_wdata;
      if (ram_wren1) mem1[ram_addr] <= ram_wdata;
      ram_q0 <= ram_wren0 ? ram_wdata : mem0[ram_addr];
      ram_q1 <= ram_wren1 ? ram_wdata : mem1[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; level = 3'd0;
    draw_req = 1'b0; draw_addr = '0;
    rope_req = 1'b0; rope_we = 1'b0; rope_lock = 1'b0; rope_addr = '0; rope_wdata = '0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_draw_rvalid", draw_rvalid, 0);
    check("rst_rope_rvalid", rope_rvalid, 0);
    check("rst_lock_active", lock_active, 0);
    check("rst_wren0", ram_wren0, 0);
    check("rst_wren1", ram_wren1, 0);
    check("rst_draw_rdata", draw_rdata, 0);
    check("rst_rope_rdata", rope_rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    @(negedge clock); resetn = 1'b1;

    // Read latency: drawer reads addr 3 of bank 0
    @(negedge clock); draw_req = 1'b1; draw_addr = 4'd3; #1;
    check("rd_draw_gnt", draw_gnt, 1);
    check("rd_rope_gnt", rope_gnt, 0);
    check("rd_ram_addr", ram_addr, 3);
    @(negedge clock); draw_req = 1'b0; #1;
    check("rd_draw_rvalid", draw_rvalid, 1);
    check("rd_draw_rdata", draw_rdata, 32'h1234_5678);
    @(negedge clock); #1;
    check("rd_rvalid_pulse", draw_rvalid, 0);
    check("rd_rdata_hold", draw_rdata, 32'h1234_5678);
    check("idle_ram_addr", ram_addr, 0);

    // Starvation guard: rope wins on its 9th waiting cycle
    @(negedge clock);
    draw_req = 1'b1; draw_addr = 4'd1;
    rope_req = 1'b1; rope_we = 1'b0; rope_addr = 4'd5;
    #1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin @(negedge clock); #1; end
      check($sformatf("starve_rope_gnt_c%0d", i), rope_gnt, (i == 9));
    end
    check("starve_draw_gnt", draw_gnt, 0);
    check("starve_ram_addr", ram_addr, 5);
    @(negedge clock); rope_req = 1'b0; draw_addr = 4'd2; #1;
    check("starve_draw_resume", draw_gnt, 1);
    check("starve_rope_rvalid", rope_rvalid, 1);
    check("starve_rope_rdata", rope_rdata, 32'hA0A0_0005);
    check("starve_draw_rvalid", draw_rvalid, 0);

    // Locked read-modify-write of addr 2 with the drawer still requesting
    @(negedge clock);
    rope_req = 1'b1; rope_we = 1'b0; rope_lock = 1'b1; rope_addr = 4'd2;
    #1;
    k = 1;
    while (!rope_gnt && k < 20) begin
      @(negedge clock); #1; k++;
    end
    check("lock_grant_cycle", k, 9);
    check("lock_grant_draw_gnt", draw_gnt, 0);
    check("lock_grant_lock_active", lock_active, 0);
    @(negedge clock);
    rope_we = 1'b1; rope_lock = 1'b0; rope_wdata = 32'hABCD_0003; level = 3'd1;
    #1;
    check("rmw_lock_active", lock_active, 1);
    check("rmw_draw_gnt", draw_gnt, 0);
    check("rmw_rope_gnt", rope_gnt, 1);
    check("rmw_wren0", ram_wren0, 1);
    check("rmw_wren1", ram_wren1, 0);
    check("rmw_rope_rvalid", rope_rvalid, 1);
    check("rmw_rope_rdata", rope_rdata, 32'hA0A0_0002);
    @(negedge clock); rope_req = 1'b0; rope_we = 1'b0; #1;
    check("rmw_unlocked", lock_active, 0);
    check("rmw_draw_gnt_after", draw_gnt, 1);
    check("rmw_no_write_rvalid", rope_rvalid, 0);
    @(negedge clock); draw_req = 1'b0; #1;
    check("rmw_readback_rvalid", draw_rvalid, 1);
    check("rmw_readback_rdata", draw_rdata, 32'hABCD_0003);
    check("bank_deferred", dut.bank_sel_reg, 0);
    @(negedge clock); #1;
    check("bank_switched", dut.bank_sel_reg, 1);
    @(negedge clock); draw_req = 1'b1; draw_addr = 4'd0; #1;
    check("bank1_draw_gnt", draw_gnt, 1);
    @(negedge clock); draw_req = 1'b0; #1;
    check("bank1_rdata", draw_rdata, 32'hB1B1_0000);

    // Lock timeout: rope keeps lock=1 without requesting
    @(negedge clock); rope_req = 1'b1; rope_lock = 1'b1; rope_addr = 4'd7; #1;
    check("to_rope_gnt", rope_gnt, 1);
    @(negedge clock); rope_req = 1'b0; draw_req = 1'b1; draw_addr = 4'd4; #1;
    check("to_rope_rdata", rope_rdata, 32'hB1B1_0007);
    n = 0; saw = 1'b0;
    while (lock_active === 1'b1 && n < 100) begin
      n++;
      if (draw_gnt) saw = 1'b1;
      @(negedge clock); #1;
    end
    check("to_lock_cycles", n, 64);
    check("to_draw_blocked", saw, 0);
    check("to_draw_resume", draw_gnt, 1);

    // Async reset in the cycle after a drawer grant
    @(negedge clock); draw_addr = 4'd3; #1;
    check("ar_draw_gnt", draw_gnt, 1);
    @(negedge clock); draw_req = 1'b0; #1;
    check("ar_pre_rvalid", draw_rvalid, 1);
    check("ar_pre_rdata", draw_rdata, 32'hB1B1_0003);
    check("ar_pre_bank", dut.bank_sel_reg, 1);
    #2 resetn = 1'b0;
    #1;
    check("ar_rvalid", draw_rvalid, 0);
    check("ar_rdata", draw_rdata, 0);
    check("ar_lock_active", lock_active, 0);
    check("ar_state", dut.state_reg, 0);
    check("ar_bank", dut.bank_sel_reg, 0);
    @(negedge clock); resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
